fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding read to a variable-latency memory,
// returned words buffered with their PC in a small FIFO, flushed on redirect.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, PEND, DROP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n, mem_addr_n;
  logic              mem_req_n;
  logic [31:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, occ;
  logic              push, pop, issue;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count != '0);
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n    = state;
    fetch_pc_n = fetch_pc;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    issue      = 1'b0;
    pop        = out_valid & out_ready & ~redirect_valid;
    push       = (state == PEND) & mem_rvalid & ~redirect_valid;
    // Occupancy at the end of this cycle; a new request needs a free slot then.
    occ        = count - CNT_W'(pop) + CNT_W'(push);

    if (redirect_valid) begin
      fetch_pc_n = redirect_pc;
      mem_req_n  = 1'b0;
      unique case (state)
        IDLE:    state_n = IDLE;
        REQ:     state_n = mem_gnt ? DROP : IDLE;
        PEND:    state_n = mem_rvalid ? IDLE : DROP;
        DROP:    state_n = mem_rvalid ? IDLE : DROP;
        default: state_n = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: issue = (occ < CNT_W'(DEPTH));
        REQ: begin
          if (mem_gnt) begin
            state_n    = PEND;
            mem_req_n  = 1'b0;
            fetch_pc_n = fetch_pc + 1'b1;
          end
        end
        PEND: begin
          if (mem_rvalid) begin
            state_n = IDLE;
            issue   = (occ < CNT_W'(DEPTH));
          end
        end
        DROP:    if (mem_rvalid) state_n = IDLE;
        default: state_n = IDLE;
      endcase
      // Back-to-back issue straight out of PEND keeps zero-wait throughput at 1 per 2 cycles.
      if (issue) begin
        state_n    = REQ;
        mem_req_n  = 1'b1;
        mem_addr_n = fetch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // NOTE: FIFO storage is reset too so out_instr/out_pc read zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          instr_q[wr_ptr] <= mem_rdata;
          pc_q[wr_ptr]    <= mem_addr;
          wr_ptr          <= next_ptr(wr_ptr);
        end
        if (pop) rd_ptr <= next_ptr(rd_ptr);
        count <= occ;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural memory with configurable grant
// delay and read latency (data = addr + 0x100), handshake and grant logs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model, driven on the falling edge.
  int         gnt_dly, rv_lat, wcnt, rcnt;
  bit         model_en, busy;
  logic [7:0] gaddr;
  logic [7:0] granted_q[$];

  always @(negedge clk) begin
    if (model_en) begin
      if (!resetn) begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; busy = 1'b0; wcnt = 0;
      end else begin
        if (mem_gnt) begin busy = 1'b1; rcnt = 0; wcnt = 0; end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (busy) begin
          rcnt++;
          if (rcnt >= rv_lat) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h100 + 32'(gaddr); busy = 1'b0;
          end
        end else if (mem_req) begin
          if (wcnt >= gnt_dly) begin
            mem_gnt = 1'b1; gaddr = mem_addr; granted_q.push_back(mem_addr);
          end else wcnt++;
        end else wcnt = 0;
      end
    end
  end

  // Edge monitor: grant acceptance and request-address stability.
  int         cyc = 0, unstable = 0;
  bit         acc_pend, prev_req, prev_gnt;
  logic [7:0] acc_addr, prev_addr;

  always @(posedge clk) begin
    cyc++;
    if (resetn && prev_req && !prev_gnt && mem_req && mem_addr != prev_addr) unstable++;
    prev_req  = resetn && mem_req;
    prev_gnt  = mem_gnt;
    prev_addr = mem_addr;
    acc_pend  = resetn && mem_req && mem_gnt;
    acc_addr  = mem_addr;
  end

  // Handshake log, sampled mid-cycle.
  logic [7:0]  out_pc_q[$];
  logic [31:0] out_instr_q[$];
  int          out_cyc_q[$];

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !redirect_valid) begin
      out_pc_q.push_back(out_pc);
      out_instr_q.push_back(out_instr);
      out_cyc_q.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    out_pc_q.delete(); out_instr_q.delete(); out_cyc_q.delete(); granted_q.delete();
  endtask

  task automatic restart();
    resetn = 1'b0;
    tick(2);
    clear_logs();
    unstable = 0;
    resetn = 1'b1;
  endtask

  task automatic wait_pend(input logic [7:0] addr, input bit any_addr, input string tag);
    int n = 0;
    do begin tick(1); n++; end
    while (!(acc_pend && (any_addr || acc_addr == addr)) && n < 300);
    check(tag, 32'(acc_pend && (any_addr || acc_addr == addr)), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   32'(mem_req),   32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_instr"}, out_instr,      32'd0);
    check({tag, "_out_pc"},    32'(out_pc),    32'd0);
  endtask

  initial begin
    int old_seen;
    resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    gnt_dly = 0; rv_lat = 1; model_en = 1'b1;
    tick(2);
    check_reset_outputs("rst");

    // Zero-wait stream, always ready.
    clear_logs();
    resetn = 1'b1;
    tick(20);
    check("stream_len", 32'(out_pc_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stream_pc%0d", i), 32'(out_pc_q[i]), 32'(i));
      check($sformatf("stream_instr%0d", i), out_instr_q[i], 32'h100 + 32'(i));
    end
    for (int i = 1; i < 4; i++)
      check($sformatf("stream_gap%0d", i), 32'(out_cyc_q[i] - out_cyc_q[i-1]), 32'd2);

    // Backpressure fills exactly DEPTH entries, then drains in order.
    out_ready = 1'b0;
    restart();
    tick(20);
    check("stall_valid",   32'(out_valid), 32'd1);
    check("stall_req",     32'(mem_req),   32'd0);
    check("stall_grants",  32'(granted_q.size()), 32'd2);
    check("stall_head_pc", 32'(out_pc),    32'd0);
    check("stall_head_in", out_instr,      32'h100);
    out_ready = 1'b1;
    tick(20);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_pc%0d", i), 32'(out_pc_q[i]), 32'(i));
      check($sformatf("drain_instr%0d", i), out_instr_q[i], 32'h100 + 32'(i));
    end

    // Slow memory: 2-cycle grant delay, 3-cycle read latency.
    gnt_dly = 2; rv_lat = 3;
    restart();
    tick(60);
    check("slow_addr_stable", 32'(unstable), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("slow_grant%0d", i), 32'(granted_q[i]), 32'(i));
      check($sformatf("slow_pc%0d", i), 32'(out_pc_q[i]), 32'(i));
    end

    // Redirect while the read of address 5 is pending.
    gnt_dly = 0; rv_lat = 4;
    restart();
    wait_pend(8'h05, 1'b0, "pend5_reached");
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick(1);
    redirect_valid = 1'b0;
    check("redir_valid_t1", 32'(out_valid), 32'd0);
    check("redir_req_t1",   32'(mem_req),   32'd0);
    clear_logs();
    tick(40);
    check("redir_grant0", 32'(granted_q[0]), 32'h40);
    check("redir_pc0",    32'(out_pc_q[0]),  32'h40);
    check("redir_instr0", out_instr_q[0],    32'h140);
    old_seen = 0;
    foreach (out_pc_q[i]) if (out_pc_q[i] < 8'h40) old_seen++;
    check("redir_no_stale", 32'(old_seen), 32'd0);

    // PC wrap at the top of the address space.
    rv_lat = 1;
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick(1);
    redirect_valid = 1'b0;
    clear_logs();
    tick(20);
    check("wrap_grant0", 32'(granted_q[0]), 32'hFE);
    check("wrap_grant1", 32'(granted_q[1]), 32'hFF);
    check("wrap_grant2", 32'(granted_q[2]), 32'h00);
    check("wrap_pc2",    32'(out_pc_q[2]),  32'h00);
    check("wrap_instr2", out_instr_q[2],    32'h100);

    // Redirect coinciding with a pop and an rvalid.
    out_ready = 1'b0;
    restart();
    wait_pend(8'h01, 1'b0, "pend1_reached");
    check("coinc_valid_before", 32'(out_valid), 32'd1);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h20;
    tick(1);
    redirect_valid = 1'b0;
    check("coinc_valid_t1", 32'(out_valid), 32'd0);
    check("coinc_req_t1",   32'(mem_req),   32'd0);
    clear_logs();
    tick(20);
    check("coinc_pc0",    32'(out_pc_q[0]), 32'h20);
    check("coinc_instr0", out_instr_q[0],   32'h120);
    old_seen = 0;
    foreach (out_pc_q[i]) if (out_pc_q[i] < 8'h20) old_seen++;
    check("coinc_no_stale", 32'(old_seen), 32'd0);

    // Reset pulse while a read is pending, then a late rvalid.
    rv_lat = 3;
    wait_pend(8'h00, 1'b1, "pend_any_reached");
    model_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    resetn = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    resetn = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    tick(1);
    mem_rvalid = 1'b0;
    tick(6);
    check("late_rvalid_ignored", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
